// File: rtl/dff_async_pkg.sv
// Shared types for the dff_async flop bank: classification of the async
// control inputs into the mode that currently owns q.
package dff_async_pkg;

  typedef enum logic [1:0] {
    MODE_CAPTURE,
    MODE_PRESET,
    MODE_CLEAR
  } async_mode_e;

  // Clear beats preset; with neither asserted the clock owns q.
  function automatic async_mode_e async_mode(input logic reset, input logic set);
    if (!reset) return MODE_CLEAR;
    if (!set)   return MODE_PRESET;
    return MODE_CAPTURE;
  endfunction

endpackage

// File: rtl/dff_async_bit.sv
// Single-bit D flop with async active-low clear and preset, plus complement.
module dff_async_bit
  import dff_async_pkg::*;
(
  input  logic d,
  input  logic clk,
  input  logic reset,
  input  logic set,
  output logic q,
  output logic qbar
);

  logic preset_n;

  // Preset is masked while clear is active, so releasing clear with set still
  // low produces a falling edge here and q moves to 1 in that same timestep.
  assign preset_n = (async_mode(reset, set) != MODE_PRESET);

  always_ff @(posedge clk or negedge reset or negedge preset_n) begin
    if (!reset)         q <= 1'b0;
    else if (!preset_n) q <= 1'b1;
    else                q <= d;
  end

  assign qbar = ~q;

endmodule

// File: rtl/dff_async.sv
// WIDTH-bit bank of independent async clear/preset D flops sharing clk,
// reset and set; qbar is the continuous complement of q.
module dff_async
  import dff_async_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  if (WIDTH < 1) begin : g_width_check
    $error("dff_async: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_async_bit u_bit (
      .d    (d[i]),
      .clk  (clk),
      .reset(reset),
      .set  (set),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  // Simulation-only consistency checks, sampled mid-cycle when q is settled.
  always_ff @(negedge clk) begin
    if (!$isunknown(q)) begin
      assert (qbar == ~q)
        else $error("dff_async: qbar is not the complement of q");
    end
    if (async_mode(reset, set) == MODE_CLEAR) begin
      assert (q == '0)
        else $error("dff_async: q not cleared while reset is low");
    end
    if (async_mode(reset, set) == MODE_PRESET) begin
      assert (q == '1)
        else $error("dff_async: q not preset while set is low");
    end
  end

endmodule

// File: tb/tb_dff_async.sv
// Bench for dff_async: directed scenarios then random async/clock activity,
// checked against a priority-rule reference model for WIDTH=1 and WIDTH=8.
module tb_dff_async;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set = 1'b1;
  logic       d1 = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic       q1, qbar1;
  logic [7:0] q8, qbar8;

  logic       m1 = 1'bx;
  logic [7:0] m8 = 8'hxx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_async #(.WIDTH(1)) dut1 (
    .d(d1), .clk(clk), .reset(reset), .set(set), .q(q1), .qbar(qbar1)
  );

  dff_async #(.WIDTH(8)) dut8 (
    .d(d8), .clk(clk), .reset(reset), .set(set), .q(q8), .qbar(qbar8)
  );

  task automatic check_all(input string tag);
    checks++;
    assert (q1 === m1) else begin
      errors++;
      $error("FAIL %s q1 observed %b expected %b", tag, q1, m1);
    end
    checks++;
    assert (qbar1 === ~m1) else begin
      errors++;
      $error("FAIL %s qbar1 observed %b expected %b", tag, qbar1, ~m1);
    end
    checks++;
    assert (q8 === m8) else begin
      errors++;
      $error("FAIL %s q8 observed %h expected %h", tag, q8, m8);
    end
    checks++;
    assert (qbar8 === ~m8) else begin
      errors++;
      $error("FAIL %s qbar8 observed %h expected %h", tag, qbar8, ~m8);
    end
  endtask

  // Change inputs away from a clock edge; async controls act immediately.
  task automatic drive(input logic r, input logic s, input logic dv1,
                       input logic [7:0] dv8, input string tag);
    reset = r;
    set   = s;
    d1    = dv1;
    d8    = dv8;
    if (!r) begin
      m1 = 1'b0;
      m8 = 8'h00;
    end else if (!s) begin
      m1 = 1'b1;
      m8 = 8'hFF;
    end
    #1;
    check_all(tag);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (reset && set) begin
      m1 = d1;
      m8 = d8;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Power-up: q unknown, so only drive until the first edge.
    #3;
    d1 = 1'b1;
    d8 = 8'hA5;
    tick("capture");                           // t=6
    tick("capture_hold");                      // t=16
    #3 drive(1'b0, 1'b1, 1'b1, 8'h3C, "async_reset");   // t=19
    tick("reset_ignores_clk");                 // t=26
    #3 drive(1'b1, 1'b0, 1'b0, 8'h00, "release_into_set");
    tick("set_ignores_clk");
    #3 drive(1'b1, 1'b1, 1'b0, 8'h00, "set_release_holds");
    drive(1'b1, 1'b1, 1'b1, 8'h81, "d_between_edges");
    tick("capture_after_set");
    drive(1'b1, 1'b1, 1'b0, 8'h7E, "d_low");
    tick("capture_zero");
    drive(1'b0, 1'b0, 1'b1, 8'hFF, "both_low");
    drive(1'b1, 1'b0, 1'b1, 8'hFF, "release_reset_first");
    drive(1'b1, 1'b1, 1'b0, 8'hA5, "release_set");
    tick("width_capture");
    drive(1'b1, 1'b0, 1'b0, 8'h00, "width_set");
    drive(1'b0, 1'b0, 1'b0, 8'h00, "width_reset");
    drive(1'b1, 1'b1, 1'b1, 8'h5A, "width_release");
    tick("width_recapture");

    for (int i = 0; i < 200; i++) begin
      int unsigned n;
      n = $urandom_range(0, 3);
      for (int k = 0; k < int'(n); k++) begin
        drive(($urandom_range(0, 5) != 0), ($urandom_range(0, 4) != 0),
              1'($urandom), 8'($urandom), "random_async");
      end
      tick("random_clk");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
